// File: rtl/decode_stage_p.sv
// decode_stage_p: parametrised decode stage with bypassed register file, load-use bubbling and ID/EX register
module decode_stage_p #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CTRL_W = 15,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [15:0]       instr_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] pc2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [1:0]        reg_dst_i,
  input  logic [1:0]        imm_size_i,
  input  logic              zero_ex_i,
  input  logic              uses_rs1_i,
  input  logic              uses_rs2_i,
  input  logic              reg_write_i,
  input  logic              mem_write_i,
  input  logic              mem_read_i,
  input  logic              branch_i,
  input  logic              jump_i,
  input  logic              halt_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wb_en_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] pc2_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  output logic [REG_AW-1:0] wr_addr_o,
  output logic              reg_write_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic              branch_o,
  output logic              jump_o,
  output logic              halt_o,
  output logic              jal_o,
  output logic              hazard_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc2;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] wr_addr;
    logic              reg_write;
    logic              mem_write;
    logic              mem_read;
    logic              branch;
    logic              jump;
    logic              halt;
    logic              jal;
  } idex_t;
  logic [DATA_W-1:0] rf_q [2**REG_AW];
  logic [DATA_W-1:0] rf_d [2**REG_AW];
  idex_t             idex_q, idex_d, dec;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] rs1, rs2, wr_addr;
  logic [DATA_W-1:0] imm;
  logic              sx, hazard;
  assign rs1 = REG_AW'(instr_i[10:8]);
  assign rs2 = REG_AW'(instr_i[7:5]);
  assign sx = ~zero_ex_i;
  assign imm = imm_size_i == 2'b00 ? {{(DATA_W-5){sx & instr_i[4]}}, instr_i[4:0]} :
               imm_size_i == 2'b01 ? {{(DATA_W-8){sx & instr_i[7]}}, instr_i[7:0]} :
               imm_size_i == 2'b10 ? {{(DATA_W-11){sx & instr_i[10]}}, instr_i[10:0]} : '0;
  assign wr_addr = reg_dst_i == 2'b00 ? REG_AW'(instr_i[7:5]) :
                   reg_dst_i == 2'b01 ? REG_AW'(instr_i[4:2]) :
                   reg_dst_i == 2'b10 ? REG_AW'(instr_i[10:8]) : '1;
  assign hazard = idex_q.valid & idex_q.mem_read & idex_q.reg_write & valid_i &
                  ((uses_rs1_i & (idex_q.wr_addr == rs1)) | (uses_rs2_i & (idex_q.wr_addr == rs2)));
  always_comb begin
    rf_d = rf_q;
    if (wb_en_i) rf_d[wb_addr_i] = wb_data_i;
    dec.valid = valid_i;
    dec.rd1 = (wb_en_i && wb_addr_i == rs1) ? wb_data_i : rf_q[rs1];
    dec.rd2 = (wb_en_i && wb_addr_i == rs2) ? wb_data_i : rf_q[rs2];
    dec.imm = imm;
    dec.pc = pc_i;
    dec.pc2 = pc2_i;
    dec.ctrl = ctrl_i;
    dec.rs2_addr = rs2;
    dec.wr_addr = wr_addr;
    dec.reg_write = reg_write_i;
    dec.mem_write = mem_write_i;
    dec.mem_read = mem_read_i;
    dec.branch = branch_i;
    dec.jump = jump_i;
    dec.halt = halt_i;
    dec.jal = valid_i && instr_i[15:12] == 4'b0011;
    idex_d = flush_i ? '0 : stall_i ? idex_q : (hazard || !valid_i) ? '0 : dec;
    cnt_d = (!flush_i && !stall_i && hazard && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_q <= '0;
      cnt_q <= '0;
      rf_q <= '{default: '0};
    end else begin
      idex_q <= idex_d;
      cnt_q <= cnt_d;
      rf_q <= rf_d;
    end
  end
  assign valid_o = idex_q.valid;
  assign rd1_o = idex_q.rd1;
  assign rd2_o = idex_q.rd2;
  assign imm_o = idex_q.imm;
  assign pc_o = idex_q.pc;
  assign pc2_o = idex_q.pc2;
  assign ctrl_o = idex_q.ctrl;
  assign rs2_addr_o = idex_q.rs2_addr;
  assign wr_addr_o = idex_q.wr_addr;
  assign reg_write_o = idex_q.reg_write;
  assign mem_write_o = idex_q.mem_write;
  assign mem_read_o = idex_q.mem_read;
  assign branch_o = idex_q.branch;
  assign jump_o = idex_q.jump;
  assign halt_o = idex_q.halt;
  assign jal_o = idex_q.jal;
  assign hazard_o = hazard;
  assign err_o = valid_i && imm_size_i == 2'b11;
  assign bubble_cnt_o = cnt_q;
endmodule
